edge_injector: RTL

Host-side injection stage for the 4x4 mesh: accepts 20-bit flits from a local traffic source over a valid/ready handshake, buffers them in a small FIFO, and drives one network edge input link using the mesh's valid/credit flow control. It sits directly upstream of a network edge port and feeds one router input (data, valid, credit return).

---
 rtl/edge_injector_if.sv | 8 +
 rtl/edge_injector.sv | 76 +++++++
 2 files changed

// File: rtl/edge_injector_if.sv
// edge_injector_if: host-side valid/ready flit handshake into the edge injector.
interface edge_injector_if;
  logic [19:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/edge_injector.sv
// edge_injector: buffers host flits in a FIFO and drives one mesh edge link with credit flow control.
// Optional EDGE_INJECTOR_STATS_EN adds the sent_cnt port (flits sent, wrapping).
module edge_injector #(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic RST,
  input  logic [3:0] position,
  edge_injector_if.slave host,
  output logic [19:0] o,
  output logic vo,
  input  logic ci,
  output logic [1:0] st,
  output logic err,
  output logic [7:0] drop_cnt
`ifdef EDGE_INJECTOR_STATS_EN
  , output logic [15:0] sent_cnt
`endif
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] CMAX = 4'(CREDITS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  logic [19:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic [3:0] cred, cred_n;
  logic [1:0] st_n;
  logic acc, drop, push, send, ovf;
  assign host.ready = cnt != DEPTH;
  // send uses the registered credit count, so a credit arriving now only helps next cycle
  always_comb begin
    acc = host.valid & host.ready;
    drop = acc & (host.data[19:16] == position);
    push = acc & ~drop;
    send = (cnt != '0) & (cred != '0);
    ovf = ci & ~send & (cred == CMAX);
    cnt_n = cnt + (AW+1)'(push) - (AW+1)'(send);
    cred_n = (ci & ~send & ~ovf) ? cred + 4'd1 : (send & ~ci) ? cred - 4'd1 : cred;
    st_n = (cnt_n == '0) ? IDLE : (cred_n != '0) ? SEND : STALL;
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= host.data;
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      cred <= CMAX;
      o <= '0;
      vo <= 1'b0;
      st <= IDLE;
      err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (send) begin
        rp <= rp + AW'(1);
        o <= mem[rp];
      end
      vo <= send;
      cnt <= cnt_n;
      cred <= cred_n;
      st <= st_n;
      err <= err | ovf;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
`ifdef EDGE_INJECTOR_STATS_EN
  always_ff @(posedge clk or posedge RST)
    if (RST) sent_cnt <= '0;
    else if (send) sent_cnt <= sent_cnt + 16'd1;
`endif
endmodule
